instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/wisc_seq_pkg.sv | 21 ++
 rtl/seq_wait_timer.sv | 31 +++
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wisc_seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// memory address select encodings and the default wait-timeout bound.
package wisc_seq_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    MEM        = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6,
    ERROR      = 3'd7
  } seq_state_e;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts wait cycles without mem_done; expired flags the last permitted
// wait cycle so the sequencer faults on the following edge.
module seq_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The cycle in which the count would reach MAX_WAIT is the last one allowed.
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, optional memory access and
// writeback, with stall handling, wait timeout and sticky halt/error states.
module instr_sequencer
  import wisc_seq_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_stall,
  input  logic       mem_done,
  input  logic       mem_err,
  input  logic       dec_memRead,
  input  logic       dec_memWrite,
  input  logic       dec_RegWrite,
  input  logic       dec_halt,
  output logic       mem_en,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       halted,
  output logic       err,
  output logic [2:0] state
);

  seq_state_e state_q;
  seq_state_e state_d;
  logic       tmr_clear;
  logic       tmr_enable;
  logic       tmr_expired;

  seq_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // mem_err outranks mem_done, which outranks the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (mem_err)         state_d = ERROR;
        else if (!mem_stall) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (mem_err)          state_d = ERROR;
        else if (mem_done)    state_d = DECODE;
        else if (tmr_expired) state_d = ERROR;
      end
      DECODE: begin
        if (dec_halt)                         state_d = HALT;
        else if (dec_memRead || dec_memWrite) state_d = MEM;
        else                                  state_d = WB;
      end
      MEM: begin
        if (mem_err)         state_d = ERROR;
        else if (!mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_err)          state_d = ERROR;
        else if (mem_done)    state_d = WB;
        else if (tmr_expired) state_d = ERROR;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  assign tmr_clear  = ((state_q == FETCH) && (state_d == FETCH_WAIT)) ||
                      ((state_q == MEM)   && (state_d == MEM_WAIT));
  assign tmr_enable = ((state_q == FETCH_WAIT) || (state_q == MEM_WAIT)) && !mem_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= halted || (state_d == HALT);
      err     <= err    || (state_d == ERROR);
    end
  end

  // Enables are forced low while reset is held, abandoning any access in flight.
  always_comb begin
    mem_en   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = ADDR_PC;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          mem_en   = 1'b1;
          addr_sel = ADDR_PC;
        end
        FETCH_WAIT: ir_we = mem_done && !mem_err;
        MEM: begin
          mem_en   = 1'b1;
          mem_wr   = dec_memWrite;
          addr_sel = ADDR_ALU;
        end
        WB: begin
          pc_we = 1'b1;
          rf_we = dec_RegWrite;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed-vector bench for instr_sequencer: each cycle drives inputs,
// then compares the packed outputs against hand-computed values.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_stall, mem_done, mem_err;
  logic       dec_memRead, dec_memWrite, dec_RegWrite, dec_halt;
  logic       mem_en, mem_wr, addr_sel, ir_we, pc_we, rf_we, halted, err;
  logic [2:0] state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  instr_sequencer #(.MAX_WAIT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done),
    .mem_err      (mem_err),
    .dec_memRead  (dec_memRead),
    .dec_memWrite (dec_memWrite),
    .dec_RegWrite (dec_RegWrite),
    .dec_halt     (dec_halt),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .addr_sel     (addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .halted       (halted),
    .err          (err),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d en/wr/as/ir/pc/rf/h/e=%b want st=%0d en/wr/as/ir/pc/rf/h/e=%b",
               tag, got[10:8], got[7:0], exp[10:8], exp[7:0]);
    end
  endtask

  // Expected vector: {state, mem_en, mem_wr, addr_sel, ir_we, pc_we, rf_we, halted, err}
  function automatic logic [10:0] ex(input logic [2:0] st, input logic [7:0] fl);
    return {st, fl};
  endfunction

  localparam logic [7:0] F_NONE  = 8'b0000_0000;
  localparam logic [7:0] F_FETCH = 8'b1000_0000;
  localparam logic [7:0] F_IR    = 8'b0001_0000;
  localparam logic [7:0] F_LD    = 8'b1010_0000;
  localparam logic [7:0] F_ST    = 8'b1110_0000;
  localparam logic [7:0] F_WBRF  = 8'b0000_1100;
  localparam logic [7:0] F_WBPC  = 8'b0000_1000;
  localparam logic [7:0] F_HALT  = 8'b0000_0010;
  localparam logic [7:0] F_ERR   = 8'b0000_0001;

  task automatic drv(input logic s, input logic d, input logic e);
    mem_stall = s; mem_done = d; mem_err = e;
  endtask

  task automatic dec(input logic rd, input logic wr, input logic rw, input logic h);
    dec_memRead = rd; dec_memWrite = wr; dec_RegWrite = rw; dec_halt = h;
  endtask

  // Settle, compare, then advance to the next falling edge.
  task automatic step(input string tag, input logic [10:0] exp);
    #1;
    check(tag, {state, mem_en, mem_wr, addr_sel, ir_we, pc_we, rf_we, halted, err}, exp);
    @(negedge clk);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, {state, mem_en, mem_wr, addr_sel, ir_we, pc_we, rf_we, halted, err},
          ex(3'd0, F_NONE));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b1, 1'b0);
    dec(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    step("reset_hold", ex(3'd0, F_NONE));
    rst_n = 1'b1;

    // ADD: 0,1,2,5,0
    dec(1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b0, 1'b0, 1'b0); step("add_fetch", ex(3'd0, F_FETCH));
    drv(1'b0, 1'b1, 1'b0); step("add_fwait", ex(3'd1, F_IR));
    drv(1'b0, 1'b0, 1'b0); step("add_decode", ex(3'd2, F_NONE));
    step("add_wb", ex(3'd5, F_WBRF));

    // LD with three stalled MEM cycles
    step("ld_fetch", ex(3'd0, F_FETCH));
    dec(1'b1, 1'b0, 1'b1, 1'b0);
    drv(1'b0, 1'b1, 1'b0); step("ld_fwait", ex(3'd1, F_IR));
    drv(1'b0, 1'b0, 1'b0); step("ld_decode", ex(3'd2, F_NONE));
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b0); step($sformatf("ld_mem_stall%0d", i), ex(3'd3, F_LD));
    end
    drv(1'b0, 1'b0, 1'b0); step("ld_mem_go", ex(3'd3, F_LD));
    drv(1'b0, 1'b1, 1'b0); step("ld_mwait", ex(3'd4, F_NONE));
    drv(1'b0, 1'b0, 1'b0); step("ld_wb", ex(3'd5, F_WBRF));

    // ST, with a stalled fetch where mem_done must be ignored
    dec(1'b0, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 1'b0); step("st_fetch_stall", ex(3'd0, F_FETCH));
    drv(1'b0, 1'b0, 1'b0); step("st_fetch", ex(3'd0, F_FETCH));
    drv(1'b0, 1'b1, 1'b0); step("st_fwait", ex(3'd1, F_IR));
    drv(1'b0, 1'b0, 1'b0); step("st_decode", ex(3'd2, F_NONE));
    step("st_mem", ex(3'd3, F_ST));
    drv(1'b0, 1'b1, 1'b0); step("st_mwait", ex(3'd4, F_NONE));
    drv(1'b0, 1'b0, 1'b0); step("st_wb", ex(3'd5, F_WBPC));

    // Store-with-update: read+write is a write, then register write
    dec(1'b1, 1'b1, 1'b1, 1'b0);
    step("su_fetch", ex(3'd0, F_FETCH));
    drv(1'b0, 1'b1, 1'b0); step("su_fwait", ex(3'd1, F_IR));
    step("su_decode", ex(3'd2, F_NONE));
    drv(1'b0, 1'b0, 1'b0); step("su_mem", ex(3'd3, F_ST));
    drv(1'b0, 1'b1, 1'b0); step("su_mwait", ex(3'd4, F_NONE));
    drv(1'b0, 1'b0, 1'b0); step("su_wb", ex(3'd5, F_WBRF));

    // mem_err with mem_done in MEM_WAIT
    dec(1'b1, 1'b0, 1'b1, 1'b0);
    step("le_fetch", ex(3'd0, F_FETCH));
    drv(1'b0, 1'b1, 1'b0); step("le_fwait", ex(3'd1, F_IR));
    drv(1'b0, 1'b0, 1'b0); step("le_decode", ex(3'd2, F_NONE));
    step("le_mem", ex(3'd3, F_LD));
    drv(1'b0, 1'b1, 1'b1); step("le_mwait", ex(3'd4, F_NONE));
    drv(1'b0, 1'b1, 1'b0); step("le_error0", ex(3'd7, F_ERR));
    step("le_error1", ex(3'd7, F_ERR));
    reset_pulse("le_reset");

    // Timeout: 15 cycles in FETCH_WAIT without mem_done
    drv(1'b0, 1'b0, 1'b0);
    step("to_fetch", ex(3'd0, F_FETCH));
    for (int i = 0; i < 15; i++) step($sformatf("to_fwait%0d", i), ex(3'd1, F_NONE));
    drv(1'b0, 1'b1, 1'b0); step("to_error0", ex(3'd7, F_ERR));
    drv(1'b0, 1'b0, 1'b0); step("to_error1", ex(3'd7, F_ERR));
    reset_pulse("to_reset");

    // mem_done on the 15th wait cycle is still accepted; then halt beats memWrite
    dec(1'b0, 1'b1, 1'b0, 1'b1);
    step("hb_fetch", ex(3'd0, F_FETCH));
    for (int i = 0; i < 14; i++) step($sformatf("hb_fwait%0d", i), ex(3'd1, F_NONE));
    drv(1'b0, 1'b1, 1'b0); step("hb_fwait14", ex(3'd1, F_IR));
    drv(1'b0, 1'b0, 1'b0); step("hb_decode", ex(3'd2, F_NONE));
    drv(1'b0, 1'b1, 1'b1); step("hb_halt0", ex(3'd6, F_HALT));
    step("hb_halt1", ex(3'd6, F_HALT));
    reset_pulse("hb_reset");
    drv(1'b1, 1'b0, 1'b0); step("hb_refetch", ex(3'd0, F_FETCH));

    // mem_err with mem_done in FETCH_WAIT suppresses ir_we
    drv(1'b0, 1'b0, 1'b0); step("fe_fetch", ex(3'd0, F_FETCH));
    drv(1'b0, 1'b1, 1'b1); step("fe_fwait", ex(3'd1, F_NONE));
    drv(1'b0, 1'b0, 1'b0); step("fe_error", ex(3'd7, F_ERR));
    reset_pulse("fe_reset");

    // mem_err during a fetch request
    drv(1'b1, 1'b0, 1'b1); step("fr_fetch", ex(3'd0, F_FETCH));
    drv(1'b0, 1'b0, 1'b0); step("fr_error", ex(3'd7, F_ERR));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
